// File: rtl/hdmi_video_period_sched.sv
// hdmi_video_period_sched
//
// Schedules the HDMI video-period leading edge on the TMDS side of the video
// delay line. A rising edge on the undelayed DE predicts, G_LEAD cycles later,
// the first active pixel on the delayed DE (cycle d). The block then emits an
// 8-cycle preamble (d-9..d-2) and a 2-cycle leading guard band (d-1..d) ahead
// of it. The video code itself always follows the registered delayed DE.
//
// Ports
//   i_clk          pixel clock, rising edge
//   i_reset_n      asynchronous active-low reset, synchronous release
//   i_de_early     DE before the delay line
//   i_de           DE after the delay line (aligned with encoder data)
//   o_mode         period code for the pixel sampled one cycle earlier:
//                  0 CONTROL, 1 PREAMBLE, 2 GUARD, 3 VIDEO
//   o_ctl          CTL3..CTL0 for channels 1/2 (4'b0001 during PREAMBLE)
//   o_short_blank  one-cycle pulse at d-9 when any preamble/guard cell
//                  is overridden by active video
//   o_align_err    one-cycle pulse: delayed DE disagrees with the schedule,
//                  or an early rise arrived while a schedule was pending
module hdmi_video_period_sched #(
  parameter int unsigned G_LEAD = 11
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_de_early,
  input  logic       i_de,
  output logic [1:0] o_mode,
  output logic [3:0] o_ctl,
  output logic       o_short_blank,
  output logic       o_align_err
);

  localparam int unsigned CW     = $clog2(G_LEAD + 1);
  localparam int unsigned HIST_W = 10;

  // Counter holds d - c for the current cycle c while a schedule is active.
  localparam logic [CW-1:0] ARM_CNT   = CW'(G_LEAD - 1);
  localparam logic [CW-1:0] WAIT_MIN  = CW'(10);
  localparam logic [CW-1:0] PRE_MIN   = CW'(2);
  localparam logic [CW-1:0] PRE_FIRST = CW'(9);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_PRE,
    S_GUARD
  } state_t;

  typedef enum logic [1:0] {
    M_CONTROL  = 2'd0,
    M_PREAMBLE = 2'd1,
    M_GUARD    = 2'd2,
    M_VIDEO    = 2'd3
  } mode_t;

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                short_pend, short_pend_n;
  logic [HIST_W-1:0]   hist;
  logic                de_q;

  logic                rise_early;
  logic                at_target;
  logic                arm;
  logic                running;
  mode_t               mode_n;
  logic                short_n;
  logic                err_n;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      short_pend    <= 1'b0;
      hist          <= '0;
      de_q          <= 1'b0;
      o_mode        <= M_CONTROL;
      o_ctl         <= '0;
      o_short_blank <= 1'b0;
      o_align_err   <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      short_pend    <= short_pend_n;
      hist          <= {hist[HIST_W-2:0], i_de_early};
      de_q          <= i_de;
      o_mode        <= mode_n;
      o_ctl         <= (mode_n == M_PREAMBLE) ? 4'b0001 : 4'b0000;
      o_short_blank <= short_n;
      o_align_err   <= err_n;
    end
  end

  always_comb begin
    state_n      = S_IDLE;
    cnt_n        = '0;
    short_pend_n = 1'b0;
    mode_n       = M_CONTROL;
    short_n      = 1'b0;
    err_n        = 1'b0;

    // hist[k] is i_de_early at c-1-k, so hist[0] doubles as the rise-detect
    // register and the full vector covers i_de_early at t-10..t-1, which is
    // exactly i_de at d-10..d-1: the cycles that could force a preamble or
    // guard cell to VIDEO. That lets the short-blank pulse be decided at d-9.
    rise_early = i_de_early & ~hist[0];
    at_target  = (state == S_GUARD) && (cnt == '0);
    arm        = rise_early && ((state == S_IDLE) || at_target);
    running    = (state != S_IDLE) && !at_target;

    if (arm) begin
      cnt_n        = ARM_CNT;
      short_pend_n = |hist;
    end else if (running) begin
      cnt_n        = cnt - ONE;
      short_pend_n = short_pend;
    end

    // Phase is decided from the next-cycle distance to d so that G_LEAD=10
    // can start the preamble in the cycle right after the early rise.
    if (arm || running) begin
      if (cnt_n >= WAIT_MIN) begin
        state_n = S_WAIT;
      end else if (cnt_n >= PRE_MIN) begin
        state_n = S_PRE;
      end else begin
        state_n = S_GUARD;
      end
    end

    if (i_de) begin
      mode_n = M_VIDEO;
    end else if (state_n == S_PRE) begin
      mode_n = M_PREAMBLE;
    end else if (state_n == S_GUARD) begin
      mode_n = M_GUARD;
    end

    short_n = (state_n != S_IDLE) && (cnt_n == PRE_FIRST) && short_pend_n;

    err_n = (at_target && !i_de)              // video missing at d
          || (i_de && !de_q && !at_target)    // video rise nobody scheduled
          || (rise_early && !arm);            // early rise while pending
  end

endmodule

// File: tb/tb_hdmi_video_period_sched.sv
module tb_hdmi_video_period_sched;

  localparam int G = 11;
  localparam int N = 16384;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       de_early = 1'b0;
  logic       de       = 1'b0;
  logic [1:0] mode;
  logic [3:0] ctl;
  logic       short_blank;
  logic       align_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  hdmi_video_period_sched #(.G_LEAD(G)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_de_early   (de_early),
    .i_de         (de),
    .o_mode       (mode),
    .o_ctl        (ctl),
    .o_short_blank(short_blank),
    .o_align_err  (align_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (absolute-cycle bookkeeping) -----------
  bit m_early [N];
  bit m_de    [N];
  int m_sched [N];   // 0 none, 1 preamble, 2 guard
  bit m_short [N];
  bit m_err   [N];
  int rst_cyc = 0;
  int pend_d  = -1;
  int em, c_now, dd;
  bit rise, anyh;

  function automatic bit ev(input int x);
    return (x > rst_cyc && x >= 0) ? m_early[x] : 1'b0;
  endfunction

  function automatic bit dv(input int x);
    return (x > rst_cyc && x >= 0) ? m_de[x] : 1'b0;
  endfunction

  always @(negedge clk) begin
    c_now = cyc;
    if (!rst_n) begin
      rst_cyc = c_now;
      pend_d  = -1;
      for (int i = c_now; i < c_now + 300; i++) begin
        m_sched[i] = 0;
        m_short[i] = 1'b0;
        m_err[i]   = 1'b0;
      end
      chk("rst_mode", int'(mode), 0);
      chk("rst_ctl", int'(ctl), 0);
      chk("rst_short", int'(short_blank), 0);
      chk("rst_err", int'(align_err), 0);
    end else begin
      em = dv(c_now - 1) ? 3 : m_sched[c_now];
      chk("mode", int'(mode), em);
      chk("ctl", int'(ctl), (em == 1) ? 1 : 0);
      chk("short_blank", int'(short_blank), int'(m_short[c_now]));
      chk("align_err", int'(align_err), int'(m_err[c_now]));

      m_early[c_now] = de_early;
      m_de[c_now]    = de;
      if (c_now == pend_d && !dv(c_now)) m_err[c_now + 1] = 1'b1;
      if (dv(c_now) && !dv(c_now - 1) && c_now != pend_d) m_err[c_now + 1] = 1'b1;
      rise = ev(c_now) && !ev(c_now - 1);
      if (rise) begin
        if (pend_d <= c_now) begin
          dd = c_now + G;
          // i_de over d-10..d-1 is i_de_early over t-10..t-1
          anyh = 1'b0;
          for (int k = 1; k <= 10; k++) anyh |= ev(c_now - k);
          for (int x = dd - 9; x <= dd - 2; x++) m_sched[x] = 1;
          m_sched[dd - 1] = 2;
          m_sched[dd]     = 2;
          if (anyh) m_short[dd - 9] = 1'b1;
          pend_d = dd;
        end else begin
          m_err[c_now + 1] = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit e_arr [N];
  int del_base = 0;
  int rel = 0;
  bit ln = 1'b0;
  int left = 20;
  int f;

  task automatic step(input bit e, input int force_de);
    @(posedge clk); #1;
    de_early   = e;
    e_arr[cyc] = e;
    if (force_de >= 0) de = (force_de != 0);
    else de = (cyc - G >= del_base) ? e_arr[cyc - G] : 1'b0;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    de_early = 1'($urandom_range(0, 1));
    de       = 1'($urandom_range(0, 1));
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      de_early = 1'($urandom_range(0, 1));
      de       = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst_n      = 1'b1;
    de_early   = 1'b0;
    de         = 1'b0;
    e_arr[cyc] = 1'b0;
    del_base   = cyc;
    rel        = cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with toggling DE, then early rise at relative cycle 5, line 16..115
    do_reset(8);
    for (int k = 1; k <= 130; k++) begin
      step(k >= 5 && k <= 104, -1);
      #1;
      if (k == 6)   chk("seq_mode_6", int'(mode), 0);
      if (k == 7)   chk("seq_mode_7", int'(mode), 1);
      if (k == 7)   chk("seq_ctl_7", int'(ctl), 1);
      if (k == 14)  chk("seq_mode_14", int'(mode), 1);
      if (k == 15)  chk("seq_mode_15", int'(mode), 2);
      if (k == 16)  chk("seq_mode_16", int'(mode), 2);
      if (k == 17)  chk("seq_mode_17", int'(mode), 3);
      if (k == 17)  chk("seq_ctl_17", int'(ctl), 0);
      if (k == 116) chk("seq_mode_116", int'(mode), 3);
      if (k == 117) chk("seq_mode_117", int'(mode), 0);
    end

    // short blank: early low only 4 cycles before the rise at k=34 (d=45)
    for (int k = 0; k < 80; k++) begin
      step((k < 30) || (k >= 34 && k < 54), -1);
      #1;
      if (k == 36) chk("sb_pulse", int'(short_blank), 1);
      if (k == 36) chk("sb_mode_dm9", int'(mode), 3);
      if (k == 37) chk("sb_pulse_end", int'(short_blank), 0);
      if (k == 41) chk("sb_mode_dm4", int'(mode), 3);
      if (k == 42) chk("sb_mode_dm3", int'(mode), 1);
      if (k == 44) chk("sb_mode_dm1", int'(mode), 2);
    end

    // misalignment (d=11 held low) and a spurious delayed-DE rise at k=40
    for (int k = 0; k < 60; k++) begin
      step(k <= 4, (k >= 11 && k <= 20) ? 0 : ((k >= 40 && k <= 42) ? 1 : -1));
      #1;
      if (k == 12) chk("mis_err", int'(align_err), 1);
      if (k == 12) chk("mis_mode", int'(mode), 0);
      if (k == 13) chk("mis_err_end", int'(align_err), 0);
      if (k == 41) chk("spur_err", int'(align_err), 1);
      if (k == 42) chk("spur_err_end", int'(align_err), 0);
    end

    // double early rise at k=0 and k=3
    for (int k = 0; k < 40; k++) begin
      step(k == 0 || k == 3, -1);
      #1;
      if (k == 4)  chk("dbl_err", int'(align_err), 1);
      if (k == 5)  chk("dbl_err_end", int'(align_err), 0);
      if (k == 11) chk("dbl_guard_d", int'(mode), 2);
      if (k == 12) chk("dbl_video", int'(mode), 3);
    end

    // reset in the middle of the preamble
    for (int k = 0; k <= 4; k++) begin
      step(k <= 3, -1);
      #1;
      if (k == 4) chk("mid_pre", int'(mode), 1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0; de_early = 1'b0; de = 1'b0;
    #1;
    chk("mid_async_mode", int'(mode), 0);
    chk("mid_async_ctl", int'(ctl), 0);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1; e_arr[cyc] = 1'b0; del_base = cyc;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 0);
      #1;
      chk("mid_after_release", int'(mode), 0);
    end

    // randomized lines, blanks, DE corruption and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        ln = !ln;
        if (ln) left = int'($urandom_range(1, 50));
        else if ($urandom_range(0, 3) == 0) left = int'($urandom_range(1, 12));
        else left = int'($urandom_range(10, 40));
      end
      left--;
      f = ($urandom_range(0, 59) == 0) ? int'($urandom_range(0, 1)) : -1;
      if ($urandom_range(0, 1499) == 0) do_reset(2);
      else step(ln, f);
    end
    for (int k = 0; k < 30; k++) step(1'b0, -1);

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
